// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared event codes and record layout for the count event monitor
//
// Purpose: event type encodings and the packed event record used by the
//          count monitor, its FIFO and anything that decodes ev_data.
// Contents:
//   EV_JUMP / EV_WRAP / EV_MATCH / EV_BOTH : 2-bit event type codes
//   CNT_W_DEF                              : default monitored count width
//   ev_rec_t                               : {ev_type, count} record
package count_mon_pkg;

  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] EV_JUMP  = 2'b00;
  localparam logic [1:0] EV_WRAP  = 2'b01;
  localparam logic [1:0] EV_MATCH = 2'b10;
  localparam logic [1:0] EV_BOTH  = 2'b11;

  typedef struct packed {
    logic [1:0]           ev_type;
    logic [CNT_W_DEF-1:0] count;
  } ev_rec_t;

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - single-clock FIFO with registered head output
//
// Purpose: buffers event records; the head entry is held in a register so
//          rdata_o is glitch-free and stable while it is not popped.
// Ports:
//   clk_int, reset : clock, asynchronous active-high reset
//   push_i, wdata_i: write request and record; ignored when full unless
//                    a pop happens in the same cycle
//   pop_i          : read request; ignored when empty
//   full_o, empty_o: occupancy flags
//   level_o        : number of stored entries, 0..DEPTH
//   rdata_o        : registered head record
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                     clk_int,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [WIDTH-1:0]         rdata_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             wr_en, rd_en;

  always_comb begin
    empty_o = (level_q == '0);
    full_o  = (level_q == LVL_W'(DEPTH));
    rd_en   = pop_i && !empty_o;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    wr_en   = push_i && (!full_o || rd_en);
    rd_nxt  = rd_ptr_q + 1'b1;

    // Head register tracks whatever entry will be at rd_ptr after this edge.
    // With a single stored entry being popped, the only candidate is the
    // incoming write (mem[rd_nxt] would be stale).
    head_d = head_q;
    if (rd_en) begin
      if (level_q == LVL_W'(1)) begin
        if (wr_en) head_d = wdata_i;
      end else begin
        head_d = mem[rd_nxt];
      end
    end else if (wr_en && empty_o) begin
      head_d = wdata_i;
    end

    level_d = level_q;
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_nxt;
      level_q <= level_d;
      head_q  <= head_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk_int) begin
    if (wr_en) mem[wr_ptr_q] <= wdata_i;
  end

  assign level_o = level_q;
  assign rdata_o = head_q;

endmodule

// File: rtl/count_event_fifo.sv
// rtl/count_event_fifo.sv - classifies counter transitions and queues event records
//
// Purpose: samples count every cycle, detects WRAP / MATCH / BOTH / JUMP
//          transitions against the previous sample and buffers
//          {type, count} records in event_fifo.
// Ports:
//   clk_int, reset : clock, asynchronous active-high reset
//   count          : monitored counter value
//   match_val      : threshold compared against count
//   ev_valid       : head record available
//   ev_ready       : consumer accepts the head record
//   ev_data        : head record {type[1:0], count}
//   level          : FIFO occupancy
//   overflow       : sticky, a record was dropped
//   clr_ovf        : clears overflow (a same-cycle drop wins)
module count_event_fifo
  import count_mon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk_int,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       count,
  input  logic [CNT_W-1:0]       match_val,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [CNT_W+1:0]       ev_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  logic [CNT_W-1:0] prev_count_q, prev_inc;
  logic             prev_vld_q;
  logic             overflow_q, overflow_d;
  logic             changed, is_wrap, is_match, is_seq;
  logic             ev_push, pop, drop;
  logic [1:0]       ev_type;
  logic             fifo_full, fifo_empty;

  always_comb begin
    prev_inc = prev_count_q + 1'b1;
    changed  = prev_vld_q && (count != prev_count_q);
    is_wrap  = (prev_count_q == '1) && (count == '0);
    is_match = (count == match_val);
    is_seq   = (count == prev_inc);

    // Priority: BOTH > WRAP > MATCH > JUMP; an in-sequence step is silent.
    ev_type = EV_JUMP;
    ev_push = 1'b0;
    if (changed) begin
      if (is_wrap && is_match) begin
        ev_type = EV_BOTH;
        ev_push = 1'b1;
      end else if (is_wrap) begin
        ev_type = EV_WRAP;
        ev_push = 1'b1;
      end else if (is_match) begin
        ev_type = EV_MATCH;
        ev_push = 1'b1;
      end else if (!is_seq) begin
        ev_type = EV_JUMP;
        ev_push = 1'b1;
      end
    end

    pop  = ev_valid && ev_ready;
    drop = ev_push && fifo_full && !pop;

    overflow_d = overflow_q;
    if (drop)         overflow_d = 1'b1;
    else if (clr_ovf) overflow_d = 1'b0;
  end

  always_ff @(posedge clk_int or posedge reset) begin
    if (reset) begin
      prev_count_q <= '0;
      prev_vld_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prev_count_q <= count;
      prev_vld_q   <= 1'b1;
      overflow_q   <= overflow_d;
    end
  end

  event_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W + 2)
  ) u_fifo (
    .clk_int (clk_int),
    .reset   (reset),
    .push_i  (ev_push),
    .wdata_i ({ev_type, count}),
    .pop_i   (ev_ready),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level),
    .rdata_o (ev_data)
  );

  assign ev_valid = !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_count_event_fifo.sv
// tb/tb_count_event_fifo.sv - table-driven bench for count_event_fifo
module tb_count_event_fifo;
  import count_mon_pkg::*;

  logic       clk_int = 1'b0;
  logic       reset;
  logic [3:0] count, match_val;
  logic       ev_valid, ev_ready, overflow, clr_ovf;
  logic [5:0] ev_data;
  logic [2:0] level;

  int tests_run = 0;
  int tests_failed = 0;

  count_event_fifo #(.DEPTH(4), .CNT_W(4)) dut (
    .clk_int   (clk_int),
    .reset     (reset),
    .count     (count),
    .match_val (match_val),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_data   (ev_data),
    .level     (level),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  always #5 clk_int = ~clk_int;

  typedef struct {
    logic [3:0] cnt;
    logic [3:0] mv;
    logic       rdy;
    logic       clr;
    logic       v;
    logic [5:0] d;
    logic [2:0] l;
    logic       o;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] rec(input logic [1:0] t, input logic [3:0] c);
    ev_rec_t r;
    r.ev_type = t;
    r.count   = c;
    return r;
  endfunction

  function void add(input logic [3:0] cnt, input logic [3:0] mv, input logic rdy,
                    input logic clr, input logic v, input logic [5:0] d,
                    input logic [2:0] l, input logic o);
    vec_t e;
    e.cnt = cnt; e.mv = mv; e.rdy = rdy; e.clr = clr;
    e.v = v; e.d = d; e.l = l; e.o = o;
    tbl.push_back(e);
  endfunction

  function void chk(input string name, input int idx, input logic [31:0] act,
                    input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endfunction

  task automatic check_outs(input int idx, input logic v, input logic [5:0] d,
                            input logic [2:0] l, input logic o);
    chk("ev_valid", idx, 32'(ev_valid), 32'(v));
    chk("level", idx, 32'(level), 32'(l));
    chk("overflow", idx, 32'(overflow), 32'(o));
    if (v) chk("ev_data", idx, 32'(ev_data), 32'(d));
  endtask

  logic [5:0] w0, j15;

  initial begin
    w0  = rec(EV_WRAP, 4'd0);
    j15 = rec(EV_JUMP, 4'd15);

    // Free run, match_val=5, always ready
    for (int c = 0; c <= 4; c++) add(4'(c), 4'd5, 1, 0, 0, 0, 0, 0);
    add(4'd5, 4'd5, 1, 0, 1, rec(EV_MATCH, 4'd5), 1, 0);
    for (int c = 6; c <= 15; c++) add(4'(c), 4'd5, 1, 0, 0, 0, 0, 0);
    add(4'd0, 4'd5, 1, 0, 1, w0, 1, 0);
    add(4'd1, 4'd5, 1, 0, 0, 0, 0, 0);
    add(4'd2, 4'd5, 1, 0, 0, 0, 0, 0);
    // Combined wrap+match with match_val=0
    for (int c = 3; c <= 15; c++) add(4'(c), 4'd0, 1, 0, 0, 0, 0, 0);
    add(4'd0, 4'd0, 1, 0, 1, rec(EV_BOTH, 4'd0), 1, 0);
    add(4'd1, 4'd0, 1, 0, 0, 0, 0, 0);
    // Jumps, and a jump onto match_val reported as MATCH
    add(4'd2, 4'd9, 1, 0, 0, 0, 0, 0);
    add(4'd3, 4'd9, 1, 0, 0, 0, 0, 0);
    add(4'd4, 4'd9, 1, 0, 0, 0, 0, 0);
    add(4'd0, 4'd9, 1, 0, 1, rec(EV_JUMP, 4'd0), 1, 0);
    add(4'd7, 4'd9, 1, 0, 1, rec(EV_JUMP, 4'd7), 1, 0);
    add(4'd9, 4'd9, 1, 0, 1, rec(EV_MATCH, 4'd9), 1, 0);
    add(4'd10, 4'd9, 1, 0, 0, 0, 0, 0);
    // Overflow: consumer stalled, five wraps
    for (int c = 11; c <= 15; c++) add(4'(c), 4'd5, 0, 0, 0, 0, 0, 0);
    add(4'd0,  4'd5, 0, 0, 1, w0, 1, 0);
    add(4'd15, 4'd5, 0, 0, 1, w0, 2, 0);
    add(4'd0,  4'd5, 0, 0, 1, w0, 3, 0);
    add(4'd15, 4'd5, 0, 0, 1, w0, 4, 0);
    add(4'd0,  4'd5, 0, 0, 1, w0, 4, 1);
    add(4'd15, 4'd5, 0, 0, 1, w0, 4, 1);
    add(4'd0,  4'd5, 0, 0, 1, w0, 4, 1);
    add(4'd15, 4'd5, 0, 0, 1, w0, 4, 1);
    add(4'd0,  4'd5, 0, 0, 1, w0, 4, 1);
    add(4'd0,  4'd5, 0, 1, 1, w0, 4, 0);
    // Full FIFO with simultaneous pop, then FIFO-order drain
    add(4'd15, 4'd5, 1, 0, 1, j15, 4, 0);
    add(4'd15, 4'd5, 1, 0, 1, w0, 3, 0);
    add(4'd15, 4'd5, 1, 0, 1, j15, 2, 0);
    add(4'd15, 4'd5, 1, 0, 1, j15, 1, 0);
    add(4'd15, 4'd5, 1, 0, 0, 0, 0, 0);
    // Fill to level 3 ahead of the mid-stream reset
    add(4'd0,  4'd5, 0, 0, 1, w0, 1, 0);
    add(4'd15, 4'd5, 0, 0, 1, w0, 2, 0);
    add(4'd0,  4'd5, 0, 0, 1, w0, 3, 0);

    reset = 1'b1; count = 4'd0; match_val = 4'd5; ev_ready = 1'b0; clr_ovf = 1'b0;
    #12;
    check_outs(-1, 0, 0, 0, 0);
    chk("reset ev_data", -1, 32'(ev_data), 32'd0);
    @(negedge clk_int);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_int);
      count = tbl[i].cnt; match_val = tbl[i].mv;
      ev_ready = tbl[i].rdy; clr_ovf = tbl[i].clr;
      @(posedge clk_int);
      #1;
      check_outs(i, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
    end

    // Asynchronous reset mid-cycle with level=3
    @(negedge clk_int);
    #2 reset = 1'b1;
    #1;
    check_outs(1000, 0, 0, 0, 0);
    chk("async reset ev_data", 1000, 32'(ev_data), 32'd0);
    count = 4'd7;
    @(negedge clk_int);
    reset = 1'b0;
    @(posedge clk_int); #1;
    check_outs(1001, 0, 0, 0, 0);   // first post-reset sample, count!=0
    @(negedge clk_int);
    count = 4'd8;
    @(posedge clk_int); #1;
    check_outs(1002, 0, 0, 0, 0);
    @(negedge clk_int);
    count = 4'd3; match_val = 4'd3;
    @(posedge clk_int); #1;
    check_outs(1003, 1, rec(EV_MATCH, 4'd3), 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
